d16_uart: RTL and testbench

Memory-mapped 8N1 UART slave on the d16 CPU data bus, directly downstream of the core's o_wb_* outputs, alongside main memory. The core has no ack or wait states, so this block is zero-wait: read data is combinational in the same cycle as cyc, and side effects commit at that cycle's clock edge. Contains a TX FIFO, an RX FIFO, a programmable baud divisor and status flags.

---
 rtl/d16_uart_pkg.sv | 35 +++
 rtl/d16_fifo.sv | 58 +++++
 rtl/d16_uart.sv | 308 ++++++++++++++++++++++++++++++
 tb/tb_d16_uart.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/d16_uart_pkg.sv
// d16_uart_pkg: register offsets, STATUS bit positions, shared FSM states, divisor clamp.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package d16_uart_pkg;

  // Register offsets within the 4-word window (addr[1:0])
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;
  localparam logic [1:0] REG_IE     = 2'd3;

  // STATUS bit positions
  localparam int ST_RX_VALID   = 0;
  localparam int ST_TX_FULL    = 1;
  localparam int ST_TX_BUSY    = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_FRAME_ERR  = 4;

  // Smallest divisor the bit timers will honour
  localparam logic [15:0] DIV_MIN = 16'd3;

  // Shared by the TX and RX sequencers
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  // Divisor actually loaded into the bit timers: max(div, DIV_MIN)
  function automatic logic [15:0] eff_div(input logic [15:0] div);
    return (div < DIV_MIN) ? DIV_MIN : div;
  endfunction

endpackage

// File: rtl/d16_fifo.sv
// d16_fifo: synchronous FIFO, first-word-fall-through head, 2^AW entries.
// Latency: push visible at o_dat the cycle after the push edge when empty.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
module d16_fifo #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [W-1:0]  i_dat,
  input  logic          i_pop,
  output logic [W-1:0]  o_dat,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_count
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  // Count never exceeds DEPTH, so its MSB alone marks full
  assign o_full    = r_count[AW];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dat     = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_dat;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/d16_uart.sv
// d16_uart: zero-wait memory-mapped 8N1 UART slave (D16_UART_IRQ_EN adds o_irq and IE at offset 3).
// Latency: reads combinational, writes commit at the cyc edge; o_tx falls 1 clk after a DATA write to an idle TX.
// Backpressure: none on the bus; full TX FIFO drops writes, full RX FIFO drops frames and sets rx_overrun.
module d16_uart
  import d16_uart_pkg::*;
#(
  parameter logic [15:0] BASE      = 16'hFF00,
  parameter logic [15:0] DIV_RESET = 16'd433,
  parameter int          FIFO_AW   = 3
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [15:0] i_wb_addr,
  input  logic [15:0] i_wb_dat,
  output logic [15:0] o_wb_dat,
  output logic        o_wb_sel,
  output logic        o_tx,
  input  logic        i_rx
`ifdef D16_UART_IRQ_EN
  ,
  output logic        o_irq
`endif
);

  // ---------------- bus decode ----------------
  logic [1:0]  w_reg;
  logic        w_wr;
  logic        w_rd;
  logic [15:0] w_div_eff;
  logic [15:0] w_rx_half;
  logic [15:0] r_div;
  logic        r_overrun;
  logic        r_frame_err;

  assign o_wb_sel  = i_wb_cyc && (i_wb_addr[15:2] == BASE[15:2]);
  assign w_reg     = i_wb_addr[1:0];
  assign w_wr      = o_wb_sel && i_wb_we;
  assign w_rd      = o_wb_sel && !i_wb_we;
  assign w_div_eff = eff_div(r_div);
  // (eff+1)/2 clocks in START, counter runs down to zero inclusive
  assign w_rx_half = (w_div_eff - 16'd1) >> 1;

  // ---------------- FIFOs ----------------
  logic         w_tx_push;
  logic         w_tx_pop;
  logic [7:0]   w_txf_dat;
  logic         w_txf_full;
  logic         w_txf_empty;
  logic [FIFO_AW:0] w_txf_count;
  logic         w_rx_push;
  logic         w_rx_pop;
  logic [7:0]   w_rxf_dat;
  logic         w_rxf_full;
  logic         w_rxf_empty;
  logic [FIFO_AW:0] w_rxf_count;
  logic [7:0]   r_rx_shift;

  assign w_tx_push = w_wr && (w_reg == REG_DATA);
  assign w_rx_pop  = w_rd && (w_reg == REG_DATA) && !w_rxf_empty;

  d16_fifo #(.W(8), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_tx_push),
    .i_dat   (i_wb_dat[7:0]),
    .i_pop   (w_tx_pop),
    .o_dat   (w_txf_dat),
    .o_full  (w_txf_full),
    .o_empty (w_txf_empty),
    .o_count (w_txf_count)
  );

  d16_fifo #(.W(8), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_rx_push),
    .i_dat   (r_rx_shift),
    .i_pop   (w_rx_pop),
    .o_dat   (w_rxf_dat),
    .o_full  (w_rxf_full),
    .o_empty (w_rxf_empty),
    .o_count (w_rxf_count)
  );

  // ---------------- TX sequencer ----------------
  uart_state_t r_tx_state;
  logic [15:0] r_tx_cnt;
  logic [2:0]  r_tx_bit;
  logic [7:0]  r_tx_shift;
  logic        r_tx;
  logic        w_tx_busy;

  assign o_tx      = r_tx;
  assign w_tx_busy = !w_txf_empty || (r_tx_state != S_IDLE);
  // The shifter takes a byte when leaving IDLE or when a stop bit ends with more queued
  assign w_tx_pop  = !w_txf_empty &&
                     ((r_tx_state == S_IDLE) ||
                      ((r_tx_state == S_STOP) && (r_tx_cnt == 16'd0)));

  // TX frame sequencer: start, 8 data bits LSB first, stop; o_tx registered
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= 16'd0;
      r_tx_bit   <= 3'd0;
      r_tx_shift <= 8'd0;
      r_tx       <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (!w_txf_empty) begin
            r_tx_state <= S_START;
            r_tx_shift <= w_txf_dat;
            r_tx_cnt   <= w_div_eff;
            r_tx       <= 1'b0;
          end
        end
        S_START: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_state <= S_DATA;
            r_tx_bit   <= 3'd0;
            r_tx       <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_cnt   <= w_div_eff;
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (r_tx_cnt == 16'd0) begin
            r_tx_cnt <= w_div_eff;
            if (r_tx_bit == 3'd7) begin
              r_tx_state <= S_STOP;
              r_tx       <= 1'b1;
            end else begin
              r_tx_bit   <= r_tx_bit + 3'd1;
              r_tx       <= r_tx_shift[0];
              r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == 16'd0) begin
            if (!w_txf_empty) begin
              r_tx_state <= S_START;
              r_tx_shift <= w_txf_dat;
              r_tx_cnt   <= w_div_eff;
              r_tx       <= 1'b0;
            end else begin
              r_tx_state <= S_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- RX sequencer ----------------
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  uart_state_t r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic        w_rx_stop_smp;
  logic        w_rx_good;
  logic        w_rx_ovr_evt;
  logic        w_rx_ferr_evt;

  // Two-flop synchronizer plus one history flop for falling-edge detection
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= i_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_stop_smp = (r_rx_state == S_STOP) && (r_rx_cnt == 16'd0);
  assign w_rx_good     = w_rx_stop_smp && r_rx_s2;
  // A same-cycle CPU pop makes room, so only a full FIFO with no pop overruns
  assign w_rx_push     = w_rx_good && (!w_rxf_full || w_rx_pop);
  assign w_rx_ovr_evt  = w_rx_good && w_rxf_full && !w_rx_pop;
  assign w_rx_ferr_evt = w_rx_stop_smp && !r_rx_s2;

  // RX frame sequencer: mid-bit sampling from the start-bit falling edge
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= 16'd0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'd0;
    end else begin
      case (r_rx_state)
        S_IDLE: begin
          if (r_rx_s3 && !r_rx_s2) begin
            r_rx_state <= S_START;
            r_rx_cnt   <= w_rx_half;
          end
        end
        S_START: begin
          if (r_rx_cnt == 16'd0) begin
            if (r_rx_s2) begin
              r_rx_state <= S_IDLE;     // line back high: glitch, not a start bit
            end else begin
              r_rx_state <= S_DATA;
              r_rx_bit   <= 3'd0;
              r_rx_cnt   <= w_div_eff;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (r_rx_cnt == 16'd0) begin
            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
            r_rx_cnt   <= w_div_eff;
            if (r_rx_bit == 3'd7) r_rx_state <= S_STOP;
            else                  r_rx_bit   <= r_rx_bit + 3'd1;
          end else begin
            r_rx_cnt <= r_rx_cnt - 16'd1;
          end
        end
        S_STOP: begin
          if (r_rx_cnt == 16'd0) r_rx_state <= S_IDLE;
          else                   r_rx_cnt   <= r_rx_cnt - 16'd1;
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // ---------------- control registers ----------------
  // Divisor and sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_div       <= DIV_RESET;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_wr && (w_reg == REG_DIV)) r_div <= i_wb_dat;
      if (w_rx_ovr_evt)                      r_overrun <= 1'b1;
      else if (w_wr && (w_reg == REG_STATUS)) r_overrun <= 1'b0;
      if (w_rx_ferr_evt)                     r_frame_err <= 1'b1;
      else if (w_wr && (w_reg == REG_STATUS)) r_frame_err <= 1'b0;
    end
  end

`ifdef D16_UART_IRQ_EN
  logic [1:0] r_ie;

  // Interrupt enables and registered interrupt request
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ie  <= 2'b00;
      o_irq <= 1'b0;
    end else begin
      if (w_wr && (w_reg == REG_IE)) r_ie <= i_wb_dat[1:0];
      o_irq <= (r_ie[0] && !w_rxf_empty) || (r_ie[1] && w_txf_empty);
    end
  end
`endif

  // ---------------- read mux ----------------
  logic [15:0] w_status;
  logic [15:0] w_rd_dat;

  // STATUS word assembly
  always_comb begin
    w_status                = 16'd0;
    w_status[ST_RX_VALID]   = !w_rxf_empty;
    w_status[ST_TX_FULL]    = w_txf_full;
    w_status[ST_TX_BUSY]    = w_tx_busy;
    w_status[ST_RX_OVERRUN] = r_overrun;
    w_status[ST_FRAME_ERR]  = r_frame_err;
  end

  // Register read select; zero outside the window so the interconnect can OR/mux freely
  always_comb begin
    w_rd_dat = 16'd0;
    case (w_reg)
      REG_DATA:   if (!w_rxf_empty) w_rd_dat = {8'd0, w_rxf_dat};
      REG_STATUS: w_rd_dat = w_status;
      REG_DIV:    w_rd_dat = r_div;
`ifdef D16_UART_IRQ_EN
      REG_IE:     w_rd_dat = {14'd0, r_ie};
`endif
      default:    w_rd_dat = 16'd0;
    endcase
  end

  assign o_wb_dat = o_wb_sel ? w_rd_dat : 16'd0;

  logic w_unused;
  assign w_unused = &{1'b0, w_txf_count, w_rxf_count};

endmodule

// File: tb/tb_d16_uart.sv
// tb_d16_uart: randomized bench with serial-frame reference model and TX scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_d16_uart;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [15:0] addr = 16'd0;
  logic [15:0] wdat = 16'd0;
  logic [15:0] o_wb_dat;
  logic        o_wb_sel;
  logic        o_tx;
  logic        tb_rx = 1'b1;
  logic        loop = 1'b0;
  logic        rx_line;
`ifdef D16_UART_IRQ_EN
  logic        o_irq;
`endif

  assign rx_line = loop ? o_tx : tb_rx;

  always #5 i_clk = ~i_clk;

  d16_uart dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wb_cyc  (cyc),
    .i_wb_we   (we),
    .i_wb_addr (addr),
    .i_wb_dat  (wdat),
    .o_wb_dat  (o_wb_dat),
    .o_wb_sel  (o_wb_sel),
    .o_tx      (o_tx),
    .i_rx      (rx_line)
`ifdef D16_UART_IRQ_EN
    ,
    .o_irq     (o_irq)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] tx_exp[$];     // bytes expected on o_tx, in order
  logic [7:0] rx_model[$];   // bytes the RX FIFO should hold
  bit         m_ovr = 0;
  bit         m_ferr = 0;
  int         mon_bl = 434;  // clocks per bit = max(DIV,3)+1
  bit         mon_en = 1;
  bit         mon_busy = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] exp_status(input bit txfull, input bit txbusy);
    return {11'd0, m_ferr, m_ovr, txbusy, txfull, rx_model.size() != 0};
  endfunction

  function automatic int bitlen(input logic [15:0] d);
    return ((d < 16'd3) ? 3 : int'(d)) + 1;
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge i_clk);
    cyc = 1'b1; we = 1'b1; addr = a; wdat = d;
    @(posedge i_clk); #1;
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d, output logic s);
    @(negedge i_clk);
    cyc = 1'b1; we = 1'b0; addr = a;
    #1;
    d = o_wb_dat; s = o_wb_sel;
    @(posedge i_clk); #1;
    cyc = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [15:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic        s;
    bus_read(a, d, s);
    check(name, d, exp);
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(16'hFF02, d);
    mon_bl = bitlen(d);
    read_check("div_readback", 16'hFF02, d);
  endtask

  task automatic clear_status();
    bus_write(16'hFF01, 16'($urandom));
    m_ovr = 0; m_ferr = 0;
  endtask

  task automatic wait_tx_done(input int budget);
    int n = 0;
    while ((tx_exp.size() != 0 || mon_busy) && n < budget) begin
      @(negedge i_clk); n++;
    end
    check("tx_drain", 16'(tx_exp.size()), 16'd0);
    repeat (4) @(negedge i_clk);
  endtask

  // Serial driver; the model is updated by the 8N1 receive rules
  task automatic rx_frame(input logic [7:0] b, input bit stop_ok);
    logic [9:0] f;
    f = {stop_ok, b, 1'b0};
    @(posedge i_clk); #1;
    for (int i = 0; i < 10; i++) begin
      tb_rx = f[i];
      repeat (mon_bl) @(posedge i_clk);
      #1;
    end
    tb_rx = 1'b1;
    repeat (2 * mon_bl) @(posedge i_clk);
    #1;
    if (!stop_ok)                m_ferr = 1;
    else if (rx_model.size() < 8) rx_model.push_back(b);
    else                         m_ovr = 1;
  endtask

  // TX monitor: decodes every frame on o_tx and scores it against tx_exp
  initial begin : tx_monitor
    bit         carry;
    bit         bad;
    bit         abort;
    int         bl;
    logic [7:0] v;
    logic       cur;
    carry = 0;
    forever begin
      if (!carry) @(negedge i_clk);
      carry = 0;
      if (mon_en && !i_reset && o_tx === 1'b0) begin
        mon_busy = 1; bl = mon_bl; v = 8'd0; bad = 0; abort = 0; cur = 1'b0;
        for (int k = 0; k < 10 * bl; k++) begin
          if (k > 0) @(negedge i_clk);
          if (!mon_en || i_reset) begin abort = 1; break; end
          if (k < bl) begin
            if (o_tx !== 1'b0) bad = 1;
          end else if (k >= 9 * bl) begin
            if (o_tx !== 1'b1) bad = 1;
          end else if ((k % bl) == 0) begin
            cur = o_tx; v[k / bl - 1] = o_tx;
          end else if (o_tx !== cur) begin
            bad = 1;
          end
        end
        if (!abort) begin
          check("tx_frame_shape", 16'(bad), 16'd0);
          check("tx_byte_expected", 16'(tx_exp.size() != 0), 16'd1);
          if (tx_exp.size() != 0) check("tx_byte", {8'd0, v}, {8'd0, tx_exp.pop_front()});
          if (tx_exp.size() != 0) begin
            @(negedge i_clk);
            check("tx_back_to_back", 16'(o_tx), 16'd0);
            carry = (o_tx === 1'b0);
          end
        end
        mon_busy = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [15:0] d;
    logic        s;
    logic [7:0]  b;
    int          lows;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); i_reset = 1'b0;
    check("reset_tx_idle", 16'(o_tx), 16'd1);
    check("reset_sel_idle", 16'(o_wb_sel), 16'd0);
    check("reset_dat_idle", o_wb_dat, 16'd0);
    read_check("reset_status", 16'hFF01, 16'h0000);
    read_check("reset_div", 16'hFF02, 16'd433);

    // Decode boundaries and reserved register
    bus_read(16'hFF00 - 16'd4, d, s);
    check("miss_sel", 16'(s), 16'd0);
    check("miss_dat", d, 16'd0);
    bus_read(16'hFF01, d, s);
    check("hit_sel", 16'(s), 16'd1);
`ifndef D16_UART_IRQ_EN
    bus_write(16'hFF03, 16'hFFFF);
    read_check("reserved_reads_zero", 16'hFF03, 16'h0000);
`endif

    // Single frame, DIV=3, with first-edge latency
    set_div(16'd3);
    tx_exp.push_back(8'hA5);
    bus_write(16'hFF00, 16'h00A5);
    @(negedge i_clk); check("tx_lat_before", 16'(o_tx), 16'd1);
    @(negedge i_clk); check("tx_lat_fall", 16'(o_tx), 16'd0);
    read_check("status_tx_busy", 16'hFF01, exp_status(0, 1));
    wait_tx_done(200);
    read_check("status_tx_idle", 16'hFF01, exp_status(0, 0));

    // Back-to-back burst of 10: shifter takes byte 0 on the next edge, FIFO holds 8 more
    for (int k = 0; k < 10; k++) begin
      b = 8'($urandom);
      if (k < 9) tx_exp.push_back(b);
      bus_write(16'hFF00, {8'($urandom), b});
    end
    read_check("burst_status_full", 16'hFF01, exp_status(1, 1));
    wait_tx_done(1000);
    read_check("burst_status_done", 16'hFF01, exp_status(0, 0));

    // Divisor below the minimum is stored as written but timed as 3
    set_div(16'd1);
    b = 8'($urandom);
    tx_exp.push_back(b);
    bus_write(16'hFF00, {8'd0, b});
    wait_tx_done(200);

    // Loopback at DIV=7
    set_div(16'd7);
    loop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b = (k == 0) ? 8'h3C : 8'($urandom);
      tx_exp.push_back(b);
      rx_model.push_back(b);
      bus_write(16'hFF00, {8'd0, b});
      wait_tx_done(400);
      read_check("loop_status_valid", 16'hFF01, exp_status(0, 0));
      read_check("loop_data", 16'hFF00, {8'd0, rx_model.pop_front()});
      read_check("loop_status_empty", 16'hFF01, exp_status(0, 0));
    end
    loop = 1'b0;
    repeat (4) @(negedge i_clk);

    // Nine frames without reading: eight stored, overrun sticky
    for (int k = 0; k < 9; k++) rx_frame(8'($urandom), 1'b1);
    read_check("ovr_status", 16'hFF01, exp_status(0, 0));
    clear_status();
    read_check("ovr_cleared", 16'hFF01, exp_status(0, 0));
    for (int k = 0; k < 9; k++) begin
      if (rx_model.size() != 0) read_check("rx_data", 16'hFF00, {8'd0, rx_model.pop_front()});
      else                      read_check("rx_data_empty", 16'hFF00, 16'h0000);
    end
    read_check("rx_drained_status", 16'hFF01, exp_status(0, 0));

    // Stop bit low: no byte, frame_err sticky
    rx_frame(8'($urandom), 1'b0);
    read_check("ferr_status", 16'hFF01, exp_status(0, 0));
    clear_status();
    read_check("ferr_cleared", 16'hFF01, exp_status(0, 0));

    // Glitch shorter than half a bit
    @(posedge i_clk); #1; tb_rx = 1'b0;
    repeat (2) @(posedge i_clk); #1; tb_rx = 1'b1;
    repeat (3 * mon_bl) @(posedge i_clk);
    read_check("glitch_status", 16'hFF01, exp_status(0, 0));
    read_check("glitch_data", 16'hFF00, 16'h0000);

    // Reset in the middle of a frame
    mon_en = 0;
    bus_write(16'hFF00, 16'h0000);
    repeat (20) @(negedge i_clk);
    check("pre_reset_tx_low", 16'(o_tx), 16'd0);
    i_reset = 1'b1;
    @(negedge i_clk);
    check("reset_abort_tx", 16'(o_tx), 16'd1);
    i_reset = 1'b0;
    lows = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge i_clk);
      if (o_tx !== 1'b1) lows++;
    end
    check("post_reset_tx_quiet", 16'(lows), 16'd0);
    read_check("post_reset_status", 16'hFF01, 16'h0000);
    read_check("post_reset_div", 16'hFF02, 16'd433);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
